// File: rtl/tstate_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : tstate_sequencer_if
// Description : Control/status bundle between the control-unit decode and the
//               T-state sequencer. The decode drives requests (master) and the
//               sequencer returns the T bus, strobes and status (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface tstate_sequencer_if #(
    parameter int T_STATES  = 4,
    parameter int CNT_WIDTH = 16
) ();
    localparam int TW = (T_STATES > 2) ? $clog2(T_STATES) : 1;

    // Requests from the control unit
    logic                 hlt_req;
    logic                 resume;
    logic                 clr_timer;
    logic                 wait_req;
    logic                 step_mode;
    logic                 step;

    // Timing and status back to the control unit
    logic [T_STATES-1:0]  T;
    logic [TW-1:0]        t_count;
    logic                 en_timer;
    logic                 advance;
    logic                 halted;
    logic                 instr_done;
    logic                 overrun;
    logic [CNT_WIDTH-1:0] instr_count;

    modport master (
        output hlt_req, resume, clr_timer, wait_req, step_mode, step,
        input  T, t_count, en_timer, advance, halted, instr_done, overrun, instr_count
    );

    modport slave (
        input  hlt_req, resume, clr_timer, wait_req, step_mode, step,
        output T, t_count, en_timer, advance, halted, instr_done, overrun, instr_count
    );
endinterface
`default_nettype wire

// File: rtl/tstate_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tstate_sequencer
// Description : Parametrised T-state timing generator. One-hot T bus, per-state
//               advance strobe, variable-length instructions (clr_timer), wait
//               states, sticky halt/resume, single-step pause, overrun flag and
//               retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tstate_sequencer #(
    parameter int T_STATES  = 4,
    parameter int CNT_WIDTH = 16
) (
    input  wire               clk,
    input  wire               reset,
    tstate_sequencer_if.slave sq
);
    localparam int TW = (T_STATES > 2) ? $clog2(T_STATES) : 1;
    localparam logic [TW-1:0] c_LAST_T = TW'(T_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    state_t               r_state;
    logic [TW-1:0]        r_t_count;
    logic                 r_en_timer;
    logic                 r_halted;
    logic                 r_instr_done;
    logic                 r_overrun;
    logic [CNT_WIDTH-1:0] r_instr_count;

    logic                 w_advance;
    logic [T_STATES-1:0]  w_t_bus;

    // Current T-state completes only while running and not stalled by halt or wait
    always_comb begin
        w_advance = (r_state == S_RUN) && !sq.hlt_req && !sq.wait_req;
    end

    // One-hot decode of the counter; the bus is dark only in IDLE
    always_comb begin
        w_t_bus = '0;
        if (r_state != S_IDLE) begin
            w_t_bus = {{(T_STATES-1){1'b0}}, 1'b1} << r_t_count;
        end
    end

    // Sequencer FSM with all status outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_t_count     <= '0;
            r_en_timer    <= 1'b0;
            r_halted      <= 1'b0;
            r_instr_done  <= 1'b0;
            r_overrun     <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_instr_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Single mandatory gap cycle after reset before T0
                    r_state    <= S_RUN;
                    r_en_timer <= 1'b1;
                end
                S_RUN: begin
                    if (sq.hlt_req) begin
                        // Halt freezes the T-state; clr_timer is ignored
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else if (sq.wait_req) begin
                        // Stretch the current T-state; nothing changes
                        r_state <= S_RUN;
                    end else if (sq.clr_timer || (r_t_count == c_LAST_T)) begin
                        // Retire: either an early end or a wrap past the last T-state
                        r_t_count     <= '0;
                        r_instr_done  <= 1'b1;
                        r_instr_count <= r_instr_count + CNT_WIDTH'(1);
                        if (!sq.clr_timer) begin
                            r_overrun <= 1'b1;
                        end
                        if (sq.step_mode) begin
                            r_state <= S_PAUSE;
                        end
                    end else begin
                        r_t_count <= r_t_count + TW'(1);
                    end
                end
                S_HALT: begin
                    // Leaving requires resume with the halt request withdrawn
                    if (sq.resume && !sq.hlt_req) begin
                        r_state  <= S_RUN;
                        r_halted <= 1'b0;
                    end
                end
                S_PAUSE: begin
                    // Halt outranks step; dropping step_mode also releases
                    if (sq.hlt_req) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else if (sq.step || !sq.step_mode) begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign sq.T           = w_t_bus;
    assign sq.t_count     = r_t_count;
    assign sq.en_timer    = r_en_timer;
    assign sq.advance     = w_advance;
    assign sq.halted      = r_halted;
    assign sq.instr_done  = r_instr_done;
    assign sq.overrun     = r_overrun;
    assign sq.instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_tstate_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tstate_sequencer
// Description : Self-checking bench for tstate_sequencer (T_STATES=4). Expected
//               retire counts are queued as stimulus is driven and compared
//               whenever the sequencer pulses instr_done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tstate_sequencer;
    localparam int T_STATES  = 4;
    localparam int CNT_WIDTH = 16;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   exp_cnt;
    int   sb_q[$];

    tstate_sequencer_if #(.T_STATES(T_STATES), .CNT_WIDTH(CNT_WIDTH)) sq_if ();

    tstate_sequencer #(.T_STATES(T_STATES), .CNT_WIDTH(CNT_WIDTH)) u_dut (
        .clk   (clk),
        .reset (reset),
        .sq    (sq_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_retire();
        exp_cnt = exp_cnt + 1;
        sb_q.push_back(exp_cnt);
    endtask

    // Every retire pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (sq_if.instr_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_retire", 32'd1, 32'd0);
            end else begin
                check("sb_retire_count", 32'(sq_if.instr_count), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic check_reset_state(input string pfx);
        check({pfx, "_T"},           32'(sq_if.T),           32'd0);
        check({pfx, "_t_count"},     32'(sq_if.t_count),     32'd0);
        check({pfx, "_en_timer"},    32'(sq_if.en_timer),    32'd0);
        check({pfx, "_advance"},     32'(sq_if.advance),     32'd0);
        check({pfx, "_halted"},      32'(sq_if.halted),      32'd0);
        check({pfx, "_instr_done"},  32'(sq_if.instr_done),  32'd0);
        check({pfx, "_overrun"},     32'(sq_if.overrun),     32'd0);
        check({pfx, "_instr_count"}, 32'(sq_if.instr_count), 32'd0);
    endtask

    // Assert reset, release it, check the IDLE gap, land on T0
    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset   = 1'b0;
        exp_cnt = 0;
        #1;
        check("idle_gap_T", 32'(sq_if.T), 32'd0);
        cyc();
        check("first_T0", 32'(sq_if.T), 32'd1);
    endtask

    initial begin
        logic [3:0] t1_seq [5];
        total = 0;
        bad   = 0;
        exp_cnt = 0;
        reset = 1'b1;
        sq_if.hlt_req   = 1'b0;
        sq_if.resume    = 1'b0;
        sq_if.clr_timer = 1'b0;
        sq_if.wait_req  = 1'b0;
        sq_if.step_mode = 1'b0;
        sq_if.step      = 1'b0;

        // 1: reset values, then full-length instruction with wrap
        cyc();
        cyc();
        check_reset_state("rst");
        reset = 1'b0;
        #1;
        check("t1_idle_T", 32'(sq_if.T), 32'd0);
        t1_seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
        expect_retire();
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("t1_T_seq", 32'(sq_if.T), 32'(t1_seq[i]));
        end
        check("t1_overrun",     32'(sq_if.overrun),     32'd1);
        check("t1_instr_done",  32'(sq_if.instr_done),  32'd1);
        check("t1_instr_count", 32'(sq_if.instr_count), 32'd1);
        check("t1_en_timer",    32'(sq_if.en_timer),    32'd1);

        // 2: two-state instructions via clr_timer at T1
        do_reset();
        for (int i = 0; i < 10; i++) begin
            sq_if.clr_timer = (i % 2 == 1);
            if (i % 2 == 1) expect_retire();
            cyc();
            check("t2_T", 32'(sq_if.T), (i % 2 == 0) ? 32'd2 : 32'd1);
            check("t2_instr_done", 32'(sq_if.instr_done), (i % 2 == 1) ? 32'd1 : 32'd0);
        end
        sq_if.clr_timer = 1'b0;
        check("t2_instr_count", 32'(sq_if.instr_count), 32'd5);
        check("t2_overrun",     32'(sq_if.overrun),     32'd0);

        // 3: wait states at T1 with clr_timer pending
        cyc();
        check("t3_at_T1", 32'(sq_if.T), 32'd2);
        sq_if.clr_timer = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sq_if.wait_req = 1'b1;
            #1;
            check("t3_wait_advance", 32'(sq_if.advance), 32'd0);
            cyc();
            check("t3_wait_T", 32'(sq_if.T), 32'd2);
            check("t3_wait_no_done", 32'(sq_if.instr_done), 32'd0);
        end
        sq_if.wait_req = 1'b0;
        #1;
        check("t3_release_advance", 32'(sq_if.advance), 32'd1);
        expect_retire();
        cyc();
        sq_if.clr_timer = 1'b0;
        check("t3_after_T", 32'(sq_if.T), 32'd1);
        check("t3_count", 32'(sq_if.instr_count), 32'd6);

        // 4: halt at T1, resume later at the same T-state
        cyc();
        sq_if.hlt_req = 1'b1;
        #1;
        check("t4_hlt_advance", 32'(sq_if.advance), 32'd0);
        cyc();
        sq_if.hlt_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            // Resume while hlt_req is still high must not leave HALT
            if (i == 1) begin
                sq_if.hlt_req = 1'b1;
                sq_if.resume  = 1'b1;
            end
            check("t4_halted",  32'(sq_if.halted),  32'd1);
            check("t4_t_count", 32'(sq_if.t_count), 32'd1);
            check("t4_T",       32'(sq_if.T),       32'd2);
            check("t4_advance", 32'(sq_if.advance), 32'd0);
            cyc();
            sq_if.hlt_req = 1'b0;
            sq_if.resume  = 1'b0;
        end
        check("t4_still_halted", 32'(sq_if.halted), 32'd1);
        sq_if.resume = 1'b1;
        cyc();
        sq_if.resume = 1'b0;
        check("t4_resumed_halted", 32'(sq_if.halted),  32'd0);
        check("t4_resumed_tcount", 32'(sq_if.t_count), 32'd1);
        sq_if.clr_timer = 1'b1;
        expect_retire();
        cyc();
        sq_if.clr_timer = 1'b0;
        check("t4_cleared_T", 32'(sq_if.T), 32'd1);

        // 5: single-step mode
        sq_if.step_mode = 1'b1;
        cyc();
        sq_if.clr_timer = 1'b1;
        expect_retire();
        cyc();
        sq_if.clr_timer = 1'b0;
        #1;
        check("t5_pause_T",       32'(sq_if.T),       32'd1);
        check("t5_pause_advance", 32'(sq_if.advance), 32'd0);
        cyc();
        cyc();
        check("t5_pause_hold_T",    32'(sq_if.T),          32'd1);
        check("t5_pause_hold_done", 32'(sq_if.instr_done), 32'd0);
        check("t5_pause_hold_adv",  32'(sq_if.advance),    32'd0);
        sq_if.step = 1'b1;
        cyc();
        sq_if.step = 1'b0;
        #1;
        check("t5_step_advance", 32'(sq_if.advance), 32'd1);
        cyc();
        check("t5_step_T1", 32'(sq_if.T), 32'd2);
        sq_if.clr_timer = 1'b1;
        expect_retire();
        cyc();
        sq_if.clr_timer = 1'b0;
        cyc();
        #1;
        check("t5_repause_adv", 32'(sq_if.advance), 32'd0);
        check("t5_repause_T",   32'(sq_if.T),       32'd1);
        sq_if.hlt_req = 1'b1;
        sq_if.step    = 1'b1;
        cyc();
        sq_if.hlt_req = 1'b0;
        sq_if.step    = 1'b0;
        check("t5_halt_over_step", 32'(sq_if.halted), 32'd1);
        sq_if.step_mode = 1'b0;
        sq_if.resume    = 1'b1;
        cyc();
        sq_if.resume = 1'b0;
        check("t5_resume_halted", 32'(sq_if.halted), 32'd0);

        // 6: reset mid-instruction at T2
        cyc();
        cyc();
        check("t6_at_T2", 32'(sq_if.T), 32'd4);
        reset = 1'b1;
        cyc();
        check_reset_state("t6");
        reset   = 1'b0;
        exp_cnt = 0;
        #1;
        check("t6_idle_gap_T", 32'(sq_if.T), 32'd0);
        cyc();
        check("t6_T0", 32'(sq_if.T), 32'd1);

        cyc();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
